// File: rtl/conv1_window_addr_gen.sv
// Walks every KxK window of an IMG_H x IMG_W map (oy, ox, ky, kx order) and streams one
// input-buffer read address per cycle over a valid/ready handshake.
module conv1_window_addr_gen #(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int K          = 5,
    parameter int ROW_STRIDE = 32,
    parameter int ADDR_W     = 15
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_idle,
    output logic              ap_done,
    output logic [2:0]        mul_din0,
    output logic [12:0]       mul_din1,
    input  logic [14:0]       mul_dout,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              win_last,
    output logic              frame_last
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [2:0]    KMAX  = 3'(K - 1);
    localparam logic [XW-1:0] OXMAX = XW'(IMG_W - K);
    localparam logic [YW-1:0] OYMAX = YW'(IMG_H - K);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;

    // Counters index the beat that will be loaded next into the output register.
    logic [2:0]        kx_q, ky_q;
    logic [XW-1:0]     ox_q;
    logic [YW-1:0]     oy_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, win_q, frame_q;

    logic hs, start, load;
    logic kx_end, ky_end, ox_end, oy_end, win_d, frame_d;

    assign hs    = valid_q && addr_ready;
    assign start = (state_q == IDLE) && ap_start;
    // Stop loading once the frame_last beat sits in the output register.
    assign load  = (state_q == RUN) && (!valid_q || (addr_ready && !frame_q));

    assign kx_end  = (kx_q == KMAX);
    assign ky_end  = (ky_q == KMAX);
    assign ox_end  = (ox_q == OXMAX);
    assign oy_end  = (oy_q == OYMAX);
    assign win_d   = kx_end && ky_end;
    assign frame_d = win_d && ox_end && oy_end;

    assign mul_din0 = ky_q;
    assign mul_din1 = 13'(ROW_STRIDE);
    assign addr_d   = row_base_q + ADDR_W'(mul_dout) + ADDR_W'(ox_q) + ADDR_W'(kx_q);

    assign ap_idle    = (state_q == IDLE);
    assign ap_done    = (state_q == DONE);
    assign addr       = addr_q;
    assign addr_valid = valid_q;
    assign win_last   = win_q;
    assign frame_last = frame_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ap_start) state_d = RUN;
            RUN:     if (hs && frame_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            kx_q       <= '0;
            ky_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            valid_q    <= 1'b0;
            win_q      <= 1'b0;
            frame_q    <= 1'b0;
        end else if (start) begin
            kx_q       <= '0;
            ky_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            row_base_q <= '0;
        end else if (load) begin
            addr_q  <= addr_d;
            win_q   <= win_d;
            frame_q <= frame_d;
            valid_q <= 1'b1;
            kx_q    <= kx_end ? 3'd0 : kx_q + 3'd1;
            if (kx_end) begin
                ky_q <= ky_end ? 3'd0 : ky_q + 3'd1;
                if (ky_end) begin
                    ox_q <= ox_end ? '0 : ox_q + 1'b1;
                    if (ox_end) begin
                        oy_q       <= oy_end ? '0 : oy_q + 1'b1;
                        row_base_q <= oy_end ? '0 : row_base_q + ADDR_W'(ROW_STRIDE);
                    end
                end
            end
        end else if (hs) begin
            // Only the frame_last beat can complete without a reload.
            valid_q <= 1'b0;
            win_q   <= 1'b0;
            frame_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_conv1_window_addr_gen.sv
// Scoreboard bench: a loop-nest model pushes expected beats, a negedge monitor pops them.
module tb_conv1_window_addr_gen;
    localparam int IMG_W = 32, IMG_H = 32, K = 5, RS = 32, AW = 15;
    localparam int BEATS = (IMG_H - K + 1) * (IMG_W - K + 1) * K * K;

    logic          ap_clk = 1'b0, ap_rst_n, ap_start, ap_idle, ap_done;
    logic [2:0]    mul_din0;
    logic [12:0]   mul_din1;
    logic [14:0]   mul_dout;
    logic [AW-1:0] addr;
    logic          addr_valid, addr_ready, win_last, frame_last;

    typedef struct packed {logic [AW-1:0] a; logic wl; logic fl;} beat_t;
    beat_t sb[$];
    int checks = 0, failures = 0, beats = 0, rmode = 0;
    int first6 [6] = '{0, 1, 2, 3, 4, 32};

    always #5 ap_clk = ~ap_clk;
    assign mul_dout = {12'b0, mul_din0} * {2'b0, mul_din1};

    conv1_window_addr_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .ROW_STRIDE(RS), .ADDR_W(AW)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_idle(ap_idle),
        .ap_done(ap_done), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .addr(addr), .addr_valid(addr_valid), .addr_ready(addr_ready),
        .win_last(win_last), .frame_last(frame_last));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_frame();
        beat_t b;
        for (int oy = 0; oy <= IMG_H - K; oy++)
            for (int ox = 0; ox <= IMG_W - K; ox++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++) begin
                        b.a  = AW'(oy * RS + ky * RS + ox + kx);
                        b.wl = (ky == K - 1) && (kx == K - 1);
                        b.fl = b.wl && (ox == IMG_W - K) && (oy == IMG_H - K);
                        sb.push_back(b);
                    end
    endtask

    task automatic start_frame();
        push_frame();
        @(posedge ap_clk); #1 ap_start = 1'b1;
        @(posedge ap_clk); #1 ap_start = 1'b0;
        chk("valid_at_start_edge", addr_valid, 0);
        chk("left_idle", ap_idle, 0);
        @(posedge ap_clk); #1;
        chk("valid_one_after_start", addr_valid, 1);
    endtask

    task automatic wait_done(input bit pulse);
        bit got = 0;
        for (int n = 0; n < 60000; n++) begin
            @(negedge ap_clk);
            if (pulse) ap_start = (n == 100 || n == 7000);
            if (ap_done) begin got = 1; break; end
        end
        ap_start = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL done_timeout got=no_done exp=ap_done beats=%0d", beats);
        end
        chk("beat_count", beats, BEATS);
        chk("sb_empty", sb.size(), 0);
    endtask

    // Ready driver: always-ready, or random with a 10-cycle hold at beat 24.
    initial begin
        int hold;
        bit held;
        hold = 0; held = 0; addr_ready = 1'b1;
        forever begin
            @(posedge ap_clk); #1;
            if (rmode == 0) begin
                addr_ready = 1'b1;
                held = 0;
            end else if (hold > 0) begin
                addr_ready = 1'b0;
                hold--;
            end else if (beats == 24 && !held) begin
                addr_ready = 1'b0;
                hold = 9;
                held = 1;
            end else begin
                addr_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Monitor
    initial begin
        beat_t e;
        bit prev_stall, exp_done, exp_idle;
        logic [AW-1:0] h_a;
        logic h_wl, h_fl;
        prev_stall = 0; exp_done = 0; exp_idle = 0;
        forever begin
            @(negedge ap_clk);
            if (!ap_rst_n) begin
                prev_stall = 0; exp_done = 0; exp_idle = 0;
            end else begin
                if (ap_start && ap_idle) beats = 0;
                chk("ap_done", ap_done, exp_done);
                if (exp_done) chk("valid_low_in_done", addr_valid, 0);
                if (exp_idle) chk("idle_after_done", ap_idle, 1);
                exp_idle = exp_done;
                exp_done = 0;
                if (prev_stall) begin
                    chk("stall_valid", addr_valid, 1);
                    chk("stall_addr", addr, h_a);
                    chk("stall_win_last", win_last, h_wl);
                    chk("stall_frame_last", frame_last, h_fl);
                end
                prev_stall = addr_valid && !addr_ready;
                h_a = addr; h_wl = win_last; h_fl = frame_last;
                if (addr_valid && addr_ready) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL sb_underflow got=addr %0d exp=no_beat", addr);
                    end else begin
                        e = sb.pop_front();
                        chk("addr", addr, e.a);
                        chk("win_last", win_last, e.wl);
                        chk("frame_last", frame_last, e.fl);
                        if (beats < 6) chk("first_addrs", addr, first6[beats]);
                        if (beats == 24) begin
                            chk("beat24_addr", addr, 132);
                            chk("beat24_win_last", win_last, 1);
                        end
                        if (beats == 25) chk("beat25_addr", addr, 1);
                        if (e.fl) exp_done = 1;
                    end
                    beats++;
                end
            end
        end
    end

    initial begin
        ap_rst_n = 1'b0; ap_start = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        chk("rst_idle", ap_idle, 1);
        chk("rst_done", ap_done, 0);
        chk("rst_valid", addr_valid, 0);
        chk("rst_addr", addr, 0);
        chk("rst_win_last", win_last, 0);
        chk("rst_frame_last", frame_last, 0);
        @(negedge ap_clk) ap_rst_n = 1'b1;

        rmode = 0;
        start_frame();
        wait_done(0);

        rmode = 1;
        start_frame();
        wait_done(1);
        repeat (3) @(negedge ap_clk);
        chk("no_queued_start_idle", ap_idle, 1);
        chk("no_queued_start_valid", addr_valid, 0);

        rmode = 0;
        start_frame();
        begin
            bit got = 0;
            for (int n = 0; n < 5000; n++) begin
                @(negedge ap_clk);
                if (beats >= 500) begin got = 1; break; end
            end
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL beat500_timeout got=%0d exp=500", beats);
            end
        end
        @(posedge ap_clk); #2 ap_rst_n = 1'b0;
        #1;
        chk("abort_valid", addr_valid, 0);
        chk("abort_addr", addr, 0);
        chk("abort_win_last", win_last, 0);
        chk("abort_frame_last", frame_last, 0);
        chk("abort_idle", ap_idle, 1);
        chk("abort_done", ap_done, 0);
        sb.delete();
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk) ap_rst_n = 1'b1;
        repeat (4) @(negedge ap_clk);
        chk("abort_stays_idle", ap_idle, 1);

        start_frame();
        wait_done(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
